// File: rtl/dsp48a1_pkg.sv
// Shared constants for the DSP48A1 datapath slices: opmode field positions
// and the X/Z operand select codes used by the post-adder.
package dsp48a1_pkg;

    localparam int OPMODE_W  = 8;

    localparam int OP_X_LSB  = 0;
    localparam int OP_Z_LSB  = 2;
    localparam int OP_CIN_EN = 5;
    localparam int OP_SUB    = 7;

    localparam logic [1:0] X_ZERO = 2'b00;
    localparam logic [1:0] X_M    = 2'b01;
    localparam logic [1:0] X_P    = 2'b10;
    localparam logic [1:0] X_DAB  = 2'b11;

    localparam logic [1:0] Z_ZERO = 2'b00;
    localparam logic [1:0] Z_PCIN = 2'b01;
    localparam logic [1:0] Z_P    = 2'b10;
    localparam logic [1:0] Z_C    = 2'b11;

endpackage

// File: rtl/registered.sv
// Optional pipeline register with clock enable; REG=0 makes it a wire.
// RSTTYPE selects "SYNC" (active-high), "ASYNC" (active-high) or "ASYNC_N" (active-low).
module registered #(
    parameter int    INWIDTH = 18,
    parameter int    REG     = 1,
    parameter string RSTTYPE = "SYNC"
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               ce,
    input  logic [INWIDTH-1:0] d,
    output logic [INWIDTH-1:0] q
);

    generate
        if (REG == 0) begin : g_bypass
            logic unused_ctrl;
            assign unused_ctrl = &{1'b0, clk, rst, ce};
            assign q = d;
        end else if (RSTTYPE == "ASYNC_N") begin : g_async_n
            always_ff @(posedge clk or negedge rst) begin
                if (!rst)    q <= '0;
                else if (ce) q <= d;
            end
        end else if (RSTTYPE == "ASYNC") begin : g_async
            always_ff @(posedge clk or posedge rst) begin
                if (rst)     q <= '0;
                else if (ce) q <= d;
            end
        end else begin : g_sync
            always_ff @(posedge clk) begin
                if (rst)     q <= '0;
                else if (ce) q <= d;
            end
        end
    endgenerate

endmodule

// File: rtl/dsp_post_adder.sv
// DSP48A1 post-adder/accumulator: selects X and Z operands, adds or subtracts
// them with a gated carry-in, and drives P, its cascade copy and carry-out.
module dsp_post_adder
    import dsp48a1_pkg::*;
#(
    parameter int PREG        = 1,
    parameter int CARRYOUTREG = 1,
    parameter int OPMODEREG   = 1,
    parameter int WIDTH       = 48,
    parameter int MWIDTH      = 36
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              ce_p,
    input  logic              ce_carry,
    input  logic              ce_opmode,
    input  logic [7:0]        opmode,
    input  logic [MWIDTH-1:0] m,
    input  logic [WIDTH-1:0]  dab,
    input  logic [WIDTH-1:0]  c,
    input  logic [WIDTH-1:0]  pcin,
    input  logic              cin,
    output logic [WIDTH-1:0]  p,
    output logic [WIDTH-1:0]  pcout,
    output logic              carryout,
    output logic              carryoutf
);

    logic [OPMODE_W-1:0] op_p0;
    logic [1:0]          xsel_p0;
    logic [1:0]          zsel_p0;
    logic [WIDTH-1:0]    x_p0;
    logic [WIDTH-1:0]    z_p0;
    logic [WIDTH-1:0]    p_fb;
    logic                ci_p0;
    logic                p_loop_p0;
    logic [WIDTH:0]      sum_p0;
    logic [WIDTH-1:0]    p_p1;
    logic                co_p1;
    logic                unused_op;

    // Opmode register realigns control with operands arriving one cycle later.
    registered #(.INWIDTH(OPMODE_W), .REG(OPMODEREG), .RSTTYPE("ASYNC_N")) u_opmode_reg (
        .clk (clk),
        .rst (rst_n),
        .ce  (ce_opmode),
        .d   (opmode),
        .q   (op_p0)
    );

    assign xsel_p0   = op_p0[OP_X_LSB +: 2];
    assign zsel_p0   = op_p0[OP_Z_LSB +: 2];
    assign ci_p0     = cin & op_p0[OP_CIN_EN];
    assign unused_op = &{1'b0, op_p0[4], op_p0[6]};

    // Feedback only ever comes from the P register; without it there is nothing to accumulate.
    assign p_fb      = (PREG != 0) ? p_p1 : '0;
    assign p_loop_p0 = (PREG == 0) && ((xsel_p0 == X_P) || (zsel_p0 == Z_P));

    always_comb begin
        x_p0 = '0;
        unique case (xsel_p0)
            X_ZERO:  x_p0 = '0;
            X_M:     x_p0 = {{(WIDTH-MWIDTH){1'b0}}, m};
            X_P:     x_p0 = p_fb;
            default: x_p0 = dab;
        endcase

        z_p0 = '0;
        unique case (zsel_p0)
            Z_ZERO:  z_p0 = '0;
            Z_PCIN:  z_p0 = pcin;
            Z_P:     z_p0 = p_fb;
            default: z_p0 = c;
        endcase

        // In subtract mode the top bit of the WIDTH+1 result is the borrow flag.
        if (op_p0[OP_SUB])
            sum_p0 = {1'b0, z_p0} - ({1'b0, x_p0} + {{WIDTH{1'b0}}, ci_p0});
        else
            sum_p0 = {1'b0, z_p0} + {1'b0, x_p0} + {{WIDTH{1'b0}}, ci_p0};

        if (p_loop_p0)
            sum_p0 = '0;
    end

    // Stage p0 -> p1: optional P and carry-out registers.
    registered #(.INWIDTH(WIDTH), .REG(PREG), .RSTTYPE("ASYNC_N")) u_p_reg (
        .clk (clk),
        .rst (rst_n),
        .ce  (ce_p),
        .d   (sum_p0[WIDTH-1:0]),
        .q   (p_p1)
    );

    registered #(.INWIDTH(1), .REG(CARRYOUTREG), .RSTTYPE("ASYNC_N")) u_carry_reg (
        .clk (clk),
        .rst (rst_n),
        .ce  (ce_carry),
        .d   (sum_p0[WIDTH]),
        .q   (co_p1)
    );

    assign p         = p_p1;
    assign pcout     = p_p1;
    assign carryout  = co_p1;
    assign carryoutf = co_p1;

endmodule

// File: tb/tb_dsp_post_adder.sv
// Bench for dsp_post_adder with default parameters (all registers present):
// directed sequences, a vector table and randomized traffic against a cycle model.
module tb_dsp_post_adder;

    localparam logic [47:0] ONES = 48'hFFFF_FFFF_FFFF;

    logic        clk;
    logic        rst_n;
    logic        ce_p, ce_carry, ce_opmode;
    logic [7:0]  opmode;
    logic [35:0] m;
    logic [47:0] dab, c, pcin;
    logic        cin;
    logic [47:0] p, pcout;
    logic        carryout, carryoutf;

    int n_tests = 0;
    int n_fail  = 0;

    // Reference state: what the P, carry-out and opmode registers should hold.
    logic [47:0] mdl_p;
    logic        mdl_co;
    logic [7:0]  mdl_op;

    dsp_post_adder dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .ce_p      (ce_p),
        .ce_carry  (ce_carry),
        .ce_opmode (ce_opmode),
        .opmode    (opmode),
        .m         (m),
        .dab       (dab),
        .c         (c),
        .pcin      (pcin),
        .cin       (cin),
        .p         (p),
        .pcout     (pcout),
        .carryout  (carryout),
        .carryoutf (carryoutf)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check48(input string name, input logic [47:0] act, input logic [47:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic check1(input string name, input logic act, input logic exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %b expected %b", name, act, exp);
        end
    endtask

    task automatic check_model(input string tag);
        check48({tag, "_p"}, p, mdl_p);
        check48({tag, "_pcout"}, pcout, mdl_p);
        check1({tag, "_co"}, carryout, mdl_co);
        check1({tag, "_cof"}, carryoutf, mdl_co);
    endtask

    // Result of one operation from the rules: pick operands, then add or subtract.
    task automatic compute(output logic [47:0] res, output logic co);
        logic [63:0] x, z, need, tot;
        logic        ci;
        case (mdl_op[1:0])
            2'd0:    x = 64'd0;
            2'd1:    x = {28'd0, m};
            2'd2:    x = {16'd0, mdl_p};
            default: x = {16'd0, dab};
        endcase
        case (mdl_op[3:2])
            2'd0:    z = 64'd0;
            2'd1:    z = {16'd0, pcin};
            2'd2:    z = {16'd0, mdl_p};
            default: z = {16'd0, c};
        endcase
        ci = cin & mdl_op[5];
        if (mdl_op[7]) begin
            need = x + {63'd0, ci};
            tot  = z - need;
            res  = tot[47:0];
            co   = (z < need);
        end else begin
            tot  = z + x + {63'd0, ci};
            res  = tot[47:0];
            co   = (tot > {16'd0, ONES});
        end
    endtask

    // One clock: predict the register updates, let the edge pass, then compare.
    task automatic tick(input string tag);
        logic [47:0] nres;
        logic        nco;
        compute(nres, nco);
        @(posedge clk);
        #1;
        if (rst_n) begin
            if (ce_p)      mdl_p  = nres;
            if (ce_carry)  mdl_co = nco;
            if (ce_opmode) mdl_op = opmode;
        end
        check_model(tag);
    endtask

    typedef struct {
        logic [7:0]  op;
        logic [35:0] m;
        logic [47:0] c;
        logic [47:0] dab;
        logic [47:0] pcin;
        logic        cin;
        logic [47:0] exp_p;
        logic        exp_co;
    } vec_t;

    vec_t vecs[10];

    initial begin
        vecs[0] = '{8'h8D, 36'd5,  48'd3,   48'd0,  48'd0,    1'b0, ONES - 48'd1, 1'b1};
        vecs[1] = '{8'h8D, 36'd5,  48'd10,  48'd0,  48'd0,    1'b0, 48'd5,        1'b0};
        vecs[2] = '{8'h2C, 36'd0,  48'd7,   48'd0,  48'd0,    1'b1, 48'd8,        1'b0};
        vecs[3] = '{8'h0C, 36'd0,  48'd7,   48'd0,  48'd0,    1'b1, 48'd7,        1'b0};
        vecs[4] = '{8'h0F, 36'd0,  48'd100, 48'd23, 48'd0,    1'b0, 48'd123,      1'b0};
        vecs[5] = '{8'h05, 36'd24, 48'd0,   48'd0,  48'd1000, 1'b0, 48'd1024,     1'b0};
        vecs[6] = '{8'hAD, 36'd5,  48'd10,  48'd0,  48'd0,    1'b1, 48'd4,        1'b0};
        vecs[7] = '{8'hA0, 36'd0,  48'd0,   48'd0,  48'd0,    1'b1, ONES,         1'b1};
        vecs[8] = '{8'h0F, 36'd0,  ONES,    ONES,   48'd0,    1'b0, ONES - 48'd1, 1'b1};
        vecs[9] = '{8'h5D, 36'd5,  48'd3,   48'd0,  48'd0,    1'b0, 48'd8,        1'b0};

        rst_n = 1'b1; ce_p = 1'b1; ce_carry = 1'b1; ce_opmode = 1'b1;
        opmode = 8'h00; m = '0; dab = '0; c = '0; pcin = '0; cin = 1'b0;
        mdl_p = '0; mdl_co = 1'b0; mdl_op = '0;

        // Reset state, visible before any clock edge.
        #2 rst_n = 1'b0;
        #1;
        check48("reset_p", p, 48'd0);
        check1("reset_co", carryout, 1'b0);
        tick("reset_hold");
        rst_n = 1'b1;

        // Accumulate m=5 from P=0.
        opmode = 8'h09;
        tick("acc_load_op");
        m = 36'd5;
        for (int k = 1; k <= 4; k++) begin
            tick("acc");
            check48("acc_value", p, 48'(5 * k));
            check1("acc_co", carryout, 1'b0);
        end

        // Asynchronous reset in the middle of a cycle.
        #2 rst_n = 1'b0;
        #1;
        check48("midreset_p", p, 48'd0);
        check48("midreset_pcout", pcout, 48'd0);
        check1("midreset_co", carryout, 1'b0);
        mdl_p = '0; mdl_co = 1'b0; mdl_op = '0;
        tick("midreset_hold");
        rst_n = 1'b1;

        // Wrap-around: load all-ones through C, then accumulate m=1.
        m = '0; c = ONES; opmode = 8'h0C;
        tick("wrap_op");
        tick("wrap_load");
        check48("wrap_preload", p, ONES);
        opmode = 8'h09;
        tick("wrap_op2");
        m = 36'd1;
        tick("wrap");
        check48("wrap_p", p, 48'd0);
        check1("wrap_co", carryout, 1'b1);

        // Vector table: opmode one cycle ahead of its operands.
        foreach (vecs[i]) begin
            opmode = vecs[i].op;
            tick("vec_op");
            m = vecs[i].m; c = vecs[i].c; dab = vecs[i].dab;
            pcin = vecs[i].pcin; cin = vecs[i].cin;
            tick("vec");
            check48($sformatf("vec%0d_p", i), p, vecs[i].exp_p);
            check1($sformatf("vec%0d_co", i), carryout, vecs[i].exp_co);
        end

        // P clock enable low: P holds while inputs move.
        ce_p = 1'b0;
        for (int k = 0; k < 3; k++) begin
            m = 36'($urandom()); c = 48'($urandom()); cin = 1'($urandom());
            tick("cep_hold");
            check48("cep_hold_p", p, 48'd8);
        end
        ce_p = 1'b1;

        // Opmode enable low: a new opmode must not take effect.
        ce_opmode = 1'b0; opmode = 8'h0C; c = 48'd3; m = 36'd5; cin = 1'b0;
        tick("ceop");
        check48("ceop_hold_p", p, 48'd8);
        tick("ceop2");
        check48("ceop_hold_p2", p, 48'd8);
        ce_opmode = 1'b1;

        // Randomized traffic against the model.
        for (int k = 0; k < 300; k++) begin
            logic [63:0] r;
            opmode = 8'($urandom());
            r = {$urandom(), $urandom()};
            m = r[35:0];
            r = {$urandom(), $urandom()};
            case ($urandom_range(0, 3))
                0:       c = ONES;
                1:       c = '0;
                default: c = r[47:0];
            endcase
            r = {$urandom(), $urandom()};
            dab = ($urandom_range(0, 3) == 0) ? ONES : r[47:0];
            r = {$urandom(), $urandom()};
            pcin = r[47:0];
            cin = 1'($urandom());
            ce_p      = ($urandom_range(0, 3) != 0);
            ce_carry  = ($urandom_range(0, 3) != 0);
            ce_opmode = ($urandom_range(0, 3) != 0);
            tick("rand");
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
